// File: rtl/echo_pkg.sv
// Shared definitions for the echo stage: FSM encoding and sample-range helpers.
// No ports. Build option ECHO_FIR_EN is consumed by echo_processor, not here.
package echo_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        CALC,
        WR
    } state_t;

    // Offset-binary zero point for a dw-bit sample.
    function automatic int mid_scale(input int unsigned dw);
        return 1 << (dw - 1);
    endfunction

    // Largest two's-complement value representable in dw bits.
    function automatic int sat_max(input int unsigned dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Smallest two's-complement value representable in dw bits.
    function automatic int sat_min(input int unsigned dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/echo_if.sv
// Sample stream bundle between the ADC front end and the echo stage.
// Ports: data_in/data_valid toward the echo stage; data_out/out_valid/ready back.
// master = sample source / sink side, slave = echo_processor side.
interface echo_if #(
    parameter int unsigned DW = 10
);
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_out,
        input  out_valid,
        input  ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_out,
        output out_valid,
        output ready
    );
endinterface

// File: rtl/echo_ram.sv
// Echo delay line storage: single-port synchronous RAM, 2^AW x DW, read-before-write.
// Ports: sysclk, we (write enable), addr, wdata, rdata (valid one cycle after addr).
// Contents are not reset; the owner clears the used region after reset.
module echo_ram #(
    parameter int unsigned DW = 10,
    parameter int unsigned AW = 13
) (
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/echo_processor.sv
// Audio echo stage: mixes each offset-binary sample with an attenuated copy
// delayed by DELAY_SAMPLES samples, with saturation.
// Ports: sysclk, rst_n (async, active low), bus (echo_if.slave: data_in,
//        data_valid, data_out, out_valid, ready).
// Build option: define ECHO_FIR_EN for a single feed-forward echo; by default the
// delay line holds the output, giving decaying feedback echoes.
module echo_processor
    import echo_pkg::*;
#(
    parameter int unsigned DW            = 10,
    parameter int unsigned AW            = 13,
    parameter int unsigned DELAY_SAMPLES = 2000,
    parameter int unsigned GAIN_SHIFT    = 1
) (
    input  logic  sysclk,
    input  logic  rst_n,
    echo_if.slave bus
);

    localparam logic [AW-1:0]        PTR_LAST = AW'(DELAY_SAMPLES - 1);
    localparam logic [DW-1:0]        OUT_MID  = DW'(mid_scale(DW));
    localparam logic signed [DW:0]   SUM_MAX  = (DW+1)'(sat_max(DW));
    localparam logic signed [DW:0]   SUM_MIN  = (DW+1)'(sat_min(DW));

    state_t                 state;
    state_t                 next;
    logic [AW-1:0]          ptr;
    logic signed [DW-1:0]   x_s;
    logic signed [DW-1:0]   fb_q;
    logic                   we;
    logic [DW-1:0]          wdata;
    logic [DW-1:0]          rdata;
    logic signed [DW-1:0]   e_sh;
    logic signed [DW:0]     sum;
    logic signed [DW-1:0]   y;

    // RAM address is always the pointer: read and write share it.
    echo_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .sysclk(sysclk),
        .we    (we),
        .addr  (ptr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next;
        end
    end

    // Next state and RAM write control.
    always_comb begin
        next  = state;
        we    = 1'b0;
        wdata = '0;
        case (state)
            CLEAR: begin
                we = 1'b1;
                if (ptr == PTR_LAST) begin
                    next = IDLE;
                end
            end
            IDLE: begin
                if (bus.data_valid) begin
                    next = RD;
                end
            end
            RD:   next = CALC;
            CALC: next = WR;
            WR: begin
                we    = 1'b1;
                wdata = fb_q;
                next  = IDLE;
            end
            default: next = CLEAR;
        endcase
    end

    // Mix: sum at DW+1 bits so overflow is visible before clamping.
    always_comb begin
        e_sh = $signed(rdata) >>> GAIN_SHIFT;
        sum  = {x_s[DW-1], x_s} + {e_sh[DW-1], e_sh};
        if (sum > SUM_MAX) begin
            y = SUM_MAX[DW-1:0];
        end else if (sum < SUM_MIN) begin
            y = SUM_MIN[DW-1:0];
        end else begin
            y = sum[DW-1:0];
        end
    end

    // Pointer, sample latch and registered outputs (visible during WR).
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            x_s          <= '0;
            fb_q         <= '0;
            bus.data_out  <= OUT_MID;
            bus.out_valid <= 1'b0;
            bus.ready     <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.ready     <= (next == IDLE);
            if (state == CLEAR || state == WR) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
            end
            if (state == IDLE && bus.data_valid) begin
                x_s <= {~bus.data_in[DW-1], bus.data_in[DW-2:0]};
            end
            if (state == CALC) begin
                bus.data_out  <= {~y[DW-1], y[DW-2:0]};
                bus.out_valid <= 1'b1;
`ifdef ECHO_FIR_EN
                fb_q <= x_s;
`else
                fb_q <= y;
`endif
            end
        end
    end

endmodule

// File: tb/tb_echo_processor.sv
// Bench for echo_processor with DELAY_SAMPLES=4, GAIN_SHIFT=1: directed reset,
// impulse, saturation, latency, drop and mid-operation reset steps, then random
// samples against an arithmetic model of the echo recurrence.
module tb_echo_processor;

    localparam int unsigned DW    = 10;
    localparam int unsigned AW    = 13;
    localparam int unsigned DELAY = 4;
    localparam int unsigned GAIN  = 1;

    logic sysclk = 1'b0;
    logic rst_n;

    echo_if #(.DW(DW)) bus ();

    echo_processor #(
        .DW           (DW),
        .AW           (AW),
        .DELAY_SAMPLES(DELAY),
        .GAIN_SHIFT   (GAIN)
    ) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;
    int mbuf[DELAY];
    int midx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (mbuf[i]) mbuf[i] = 0;
        midx = 0;
    endfunction

    // y[n] = clamp(x[n] + d[n-D] / 2^G), d = y (feedback) or x (feed-forward).
    function automatic int model_step(input int d);
        int xs;
        int y;
        xs = d - 512;
        y  = xs + (mbuf[midx] >>> GAIN);
        if (y > 511)  y = 511;
        if (y < -512) y = -512;
`ifdef ECHO_FIR_EN
        mbuf[midx] = xs;
`else
        mbuf[midx] = y;
`endif
        midx = (midx + 1) % DELAY;
        return y + 512;
    endfunction

    // Poll ready, pulse data_valid (optionally two cycles), check the t+1..t+4 timeline.
    task automatic send(input logic [9:0] d, input bit dbl, output logic [9:0] got);
        int w;
        int exp;
        w = 0;
        while (bus.ready !== 1'b1 && w < 200) begin
            @(negedge sysclk);
            w++;
        end
        chk("ready_before_sample", 32'(bus.ready), 1);
        exp = model_step(int'(d));
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        @(negedge sysclk);
        if (!dbl) bus.data_valid = 1'b0;
        bus.data_in = 10'($urandom_range(0, 1023));
        chk("t1_valid_ready", 32'({bus.out_valid, bus.ready}), 0);
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        chk("t2_valid_ready", 32'({bus.out_valid, bus.ready}), 0);
        @(negedge sysclk);
        chk("t3_valid_ready", 32'({bus.out_valid, bus.ready}), 2);
        chk("t3_data_out", 32'(bus.data_out), 32'(exp));
        got = bus.data_out;
        @(negedge sysclk);
        chk("t4_valid_ready", 32'({bus.out_valid, bus.ready}), 1);
        chk("t4_data_held", 32'(bus.data_out), 32'(exp));
    endtask

    // Release reset and check CLEAR holds ready low for exactly DELAY cycles.
    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < int'(DELAY) - 1; i++) begin
            @(negedge sysclk);
            chk("clear_ready_low", 32'({bus.out_valid, bus.ready}), 0);
        end
        @(negedge sysclk);
        chk("clear_ready_high", 32'(bus.ready), 1);
    endtask

    task automatic impulse(input string tag);
        int exp_tbl[9];
        logic [9:0] got;
        exp_tbl = '{712, 512, 512, 512, 612, 512, 512, 512, 562};
`ifdef ECHO_FIR_EN
        exp_tbl[8] = 512;
`endif
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 10'd712 : 10'd512, 1'b0, got);
            chk(tag, 32'(got), 32'(exp_tbl[i]));
        end
    endtask

    initial begin
        logic [9:0] got;
        rst_n          = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        model_reset();

        // Reset values.
        repeat (3) @(negedge sysclk);
        chk("rst_data_out", 32'(bus.data_out), 32'h200);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        release_reset();

        // Impulse response.
        impulse("impulse_tbl");

        // Positive saturation.
        for (int i = 0; i < 10; i++) send(10'd1023, 1'b0, got);
        chk("sat_high", 32'(got), 1023);

        // Negative saturation.
        for (int i = 0; i < 10; i++) send(10'd0, 1'b0, got);
        chk("sat_low", 32'(got), 0);

        // Random samples, some with a second data_valid that must be dropped.
        for (int i = 0; i < 40; i++) begin
            send(10'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0), got);
        end

        // Reset while the in-flight sample is in CALC.
        while (bus.ready !== 1'b1) @(negedge sysclk);
        bus.data_in    = 10'd712;
        bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_out", 32'(bus.data_out), 32'h200);
        chk("midrst_valid_ready", 32'({bus.out_valid, bus.ready}), 0);
        @(negedge sysclk);
        chk("midrst_no_strobe", 32'(bus.out_valid), 0);
        @(negedge sysclk);
        chk("midrst_no_strobe2", 32'(bus.out_valid), 0);
        release_reset();
        impulse("impulse_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
